// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with one-entry valid/ready output register.
// Optional parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx_os #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_uart_rx,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_frame_err,
  output logic              o_parity_err,
  output logic              o_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W + 1);
  localparam int H  = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(H - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t            state_q;
  logic              sync1_q;
  logic              sync2_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              ferr_q;
  logic              perr_q;
  logic              ovr_q;
  logic              line;
  logic              bit_end;
  logic              can_load;
  logic              par_bad;

  assign line     = sync2_q;
  assign bit_end  = (cnt_q == CNT_LAST);
  assign can_load = ~valid_q | i_ready;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;
  assign par_bad = par_bad_q;
`else
  // Parity sense has no meaning without parity checking.
  assign par_bad = 1'b0 & ODD;
`endif

  // Bit-period counter wraps after CLKS_PER_BIT cycles.
  always_comb begin
    cnt_d = bit_end ? '0 : cnt_q + 1'b1;
  end

  // Two-flop synchroniser, idles high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_uart_rx;
      sync2_q <= sync1_q;
    end
  end

  // Frame FSM plus output register and overrun pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      ovr_q <= 1'b0;
      if (valid_q && i_ready) valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!line) state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q <= '0;
            idx_q <= '0;
            state_q <= line ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DATA: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            shreg_q <= {line, shreg_q[DATA_W-1:1]};
            if (idx_q == IDX_LAST) begin
              idx_q <= '0;
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            par_bad_q <= line ^ (^shreg_q) ^ ODD;
            state_q   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q <= line ? S_IDLE : S_BREAK;
            if (can_load) begin
              data_q  <= shreg_q;
              ferr_q  <= ~line;
              perr_q  <= par_bad;
              valid_q <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (line) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perr_q;
  assign o_overrun    = ovr_q;

endmodule
